async_receiver: RTL and testbench
=================================

ASYNC_RECEIVER -- requirements
Module: async_receiver

Interface
REQ-001 Parameter ClkFrequency, default 25000000, clock frequency in Hz.
REQ-002 Parameter Baud, default 115200, line bit rate.
REQ-003 Parameter Oversampling, default 8, ticks per bit period; SHALL be a power of two and at least 8.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 RxD  input  1  serial line, idle high, asynchronous to clk.
REQ-007 RxD_data_ready  output  1  one-cycle pulse: RxD_data holds a valid byte.
REQ-008 RxD_data  output  8  last received byte, LSB first on line.
REQ-009 RxD_framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 RxD_idle  output  1  high while line has been idle for at least 16 bit periods.
REQ-011 RxD_endofpacket  output  1  one-cycle pulse on the rising transition of RxD_idle.

Function
REQ-012 RxD SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 The oversampling tick SHALL come from a phase accumulator giving Baud*Oversampling ticks/s; ticks run whenever the block is out of reset.
REQ-014 A glitch filter SHALL update on each tick: 2-bit saturating counter moves toward the synchronized level; filtered bit changes only at 0 or 3 (reset: counter 3, bit 1).
REQ-015 Frame format SHALL be 1 start (0), 8 data bits LSB first, 1 stop (1); no parity.
REQ-016 FSM states: IDLE, START, BIT0..BIT7, STOP; 4-bit encoding.
REQ-017 IDLE->START when the filtered bit is 0.
REQ-018 START: after Oversampling/2 ticks re-sample; if 1 (false start), return to IDLE with no output; else go to BIT0.
REQ-019 Each BITn and STOP: sample the filtered bit exactly Oversampling ticks after the previous sample; shift into an 8-bit register from the MSB side.
REQ-020 STOP sample 1: load RxD_data, pulse RxD_data_ready for one clk, go to IDLE.
REQ-021 STOP sample 0: pulse RxD_framing_error, RxD_data unchanged, no data_ready, go to IDLE once the filtered bit returns to 1.
REQ-022 RxD_data_ready and RxD_framing_error SHALL never be asserted together.
REQ-023 Gap counter: clears on any filtered 0; increments once per tick in IDLE with filtered 1; saturates at 16*Oversampling; RxD_idle = saturated.
REQ-024 Back-to-back frames (start bit directly after a stop bit) SHALL be received without loss.
REQ-025 RxD_data SHALL stay stable between data_ready pulses.

Reset
REQ-026 During rst: state IDLE, shift register 0, RxD_data 0, RxD_data_ready 0, RxD_framing_error 0, gap counter 0, RxD_idle 0, RxD_endofpacket 0, accumulator 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no pulse; reception restarts on the next falling edge after rst deasserts.

Structure
REQ-028 Shared package SHALL hold FSM state constants, frame bit count (8), idle gap multiple (16) and the filter saturation value.
REQ-029 The tick generator SHALL be one sub-module, rx_tick_gen (parameters ClkFrequency, Baud*Oversampling; output tick).
REQ-030 Parameters with ClkFrequency < Baud*Oversampling SHALL be rejected at elaboration.

Verification (ClkFrequency=921600, Baud=115200, Oversampling=8: one tick per clk)
REQ-031 Send 0x55 with stop 1 -> exactly one data_ready pulse, RxD_data=0x55, framing_error never high.
REQ-032 Send 0xA3 then 0x00 back-to-back -> two data_ready pulses 80 clks apart, values 0xA3 then 0x00.
REQ-033 Send 0xFF with stop bit forced 0 -> one framing_error pulse, no data_ready, RxD_data keeps previous value.
REQ-034 Drive RxD low for 2 clks then high -> no pulses, FSM stays/returns IDLE; 3-clk-low pulse -> false start, no output.
REQ-035 Assert rst during BIT4 of 0x3C, release, send 0x81 -> no output for 0x3C, RxD_data=0x81 after one data_ready.
REQ-036 Hold RxD high 128 clks after a frame -> RxD_idle rises, RxD_endofpacket pulses once; next start bit drops RxD_idle.

Source files
------------

// File: rtl/async_receiver_pkg.sv
// Shared constants for the serial receiver: FSM state encoding, frame size,
// idle-gap multiple and glitch-filter saturation value.
package async_receiver_pkg;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StStart = 4'd1,
        StBit0  = 4'd2,
        StBit1  = 4'd3,
        StBit2  = 4'd4,
        StBit3  = 4'd5,
        StBit4  = 4'd6,
        StBit5  = 4'd7,
        StBit6  = 4'd8,
        StBit7  = 4'd9,
        StStop  = 4'd10
    } rxState_e;

    localparam int unsigned FrameBits   = 8;
    localparam int unsigned IdleGapMult = 16;
    localparam logic [1:0]  FilterMax   = 2'd3;

endpackage

// File: rtl/rx_tick_gen.sv
// Phase-accumulator tick generator: emits Rate single-cycle ticks per second
// out of a ClkFrequency Hz clock.
module rx_tick_gen #(
    parameter int unsigned ClkFrequency = 25000000,
    parameter int unsigned Rate         = 921600
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // One extra bit so acc + Inc (< 2*ClkFrequency) never wraps.
    localparam int unsigned     AccW    = $clog2(ClkFrequency) + 1;
    localparam logic [AccW-1:0] Inc     = AccW'(Rate);
    localparam logic [AccW-1:0] Modulus = AccW'(ClkFrequency);

    if (ClkFrequency < Rate) begin : gRateTooHigh
        $error("rx_tick_gen: ClkFrequency must be at least Baud*Oversampling");
    end

    logic [AccW-1:0] acc;
    logic [AccW-1:0] sum;

    assign sum = acc + Inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= Modulus) begin
            acc  <= sum - Modulus;
            tick <= 1'b1;
        end else begin
            acc  <= sum;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/async_receiver.sv
// 8N1 UART receiver: synchronizer, tick-rate glitch filter, mid-bit sampling
// FSM, plus idle-gap detection with an end-of-packet pulse.
module async_receiver
    import async_receiver_pkg::*;
#(
    parameter int unsigned ClkFrequency = 25000000,
    parameter int unsigned Baud         = 115200,
    parameter int unsigned Oversampling = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    output logic                 RxD_data_ready,
    output logic [FrameBits-1:0] RxD_data,
    output logic                 RxD_framing_error,
    output logic                 RxD_idle,
    output logic                 RxD_endofpacket
);

    localparam int unsigned     TickRate = Baud * Oversampling;
    localparam int unsigned     CntW     = $clog2(Oversampling);
    localparam int unsigned     GapMax   = IdleGapMult * Oversampling;
    localparam int unsigned     GapW     = $clog2(GapMax) + 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(Oversampling / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(Oversampling - 1);
    localparam logic [GapW-1:0] GapFull  = GapW'(GapMax);

    if (Oversampling < 8 || (Oversampling & (Oversampling - 1)) != 0) begin : gBadOversampling
        $error("async_receiver: Oversampling must be a power of two, at least 8");
    end

    logic tick;

    rx_tick_gen #(
        .ClkFrequency(ClkFrequency),
        .Rate        (TickRate)
    ) uTickGen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    logic [1:0] rxSync;
    logic       rxS;
    logic [1:0] filtCnt;
    logic [1:0] filtCntNext;
    logic       rxBit;

    assign rxS = rxSync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxSync <= 2'b11;
        end else begin
            rxSync <= {rxSync[0], RxD};
        end
    end

    always_comb begin
        filtCntNext = filtCnt;
        if (rxS && filtCnt != FilterMax) begin
            filtCntNext = filtCnt + 1'b1;
        end else if (!rxS && filtCnt != 2'd0) begin
            filtCntNext = filtCnt - 1'b1;
        end
    end

    // Filtered bit only flips once the counter saturates in either direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtCnt <= FilterMax;
            rxBit   <= 1'b1;
        end else if (tick) begin
            filtCnt <= filtCntNext;
            if (filtCntNext == FilterMax) begin
                rxBit <= 1'b1;
            end else if (filtCntNext == 2'd0) begin
                rxBit <= 1'b0;
            end
        end
    end

    rxState_e             state, stateNext;
    logic [CntW-1:0]      tickCnt, tickCntNext;
    logic [FrameBits-1:0] shiftReg, shiftNext;
    logic [FrameBits-1:0] dataNext;
    logic                 readyNext, feNext;
    logic                 waitHigh, waitHighNext;
    logic                 sample;

    assign sample = (tickCnt == ((state == StStart) ? HalfLast : FullLast));

    always_comb begin
        stateNext    = state;
        tickCntNext  = tickCnt;
        shiftNext    = shiftReg;
        dataNext     = RxD_data;
        readyNext    = 1'b0;
        feNext       = 1'b0;
        waitHighNext = waitHigh;
        if (tick) begin
            unique case (state)
                StIdle: begin
                    tickCntNext = '0;
                    if (!rxBit) stateNext = StStart;
                end
                StStart: begin
                    if (sample) begin
                        tickCntNext = '0;
                        stateNext   = rxBit ? StIdle : StBit0;
                    end else begin
                        tickCntNext = tickCnt + 1'b1;
                    end
                end
                StStop: begin
                    // After a framing error, hold off until the line is back high.
                    if (waitHigh) begin
                        if (rxBit) begin
                            waitHighNext = 1'b0;
                            stateNext    = StIdle;
                        end
                    end else if (sample) begin
                        tickCntNext = '0;
                        if (rxBit) begin
                            dataNext  = shiftReg;
                            readyNext = 1'b1;
                            stateNext = StIdle;
                        end else begin
                            feNext       = 1'b1;
                            waitHighNext = 1'b1;
                        end
                    end else begin
                        tickCntNext = tickCnt + 1'b1;
                    end
                end
                default: begin
                    if (sample) begin
                        tickCntNext = '0;
                        shiftNext   = {rxBit, shiftReg[FrameBits-1:1]};
                        stateNext   = (state == StBit7) ? StStop : rxState_e'(state + 4'd1);
                    end else begin
                        tickCntNext = tickCnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= StIdle;
            tickCnt           <= '0;
            shiftReg          <= '0;
            RxD_data          <= '0;
            RxD_data_ready    <= 1'b0;
            RxD_framing_error <= 1'b0;
            waitHigh          <= 1'b0;
        end else begin
            state             <= stateNext;
            tickCnt           <= tickCntNext;
            shiftReg          <= shiftNext;
            RxD_data          <= dataNext;
            RxD_data_ready    <= readyNext;
            RxD_framing_error <= feNext;
            waitHigh          <= waitHighNext;
        end
    end

    logic [GapW-1:0] gapCnt;
    logic            idleQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gapCnt <= '0;
            idleQ  <= 1'b0;
        end else begin
            idleQ <= RxD_idle;
            if (!rxBit) begin
                gapCnt <= '0;
            end else if (tick && state == StIdle && gapCnt != GapFull) begin
                gapCnt <= gapCnt + 1'b1;
            end
        end
    end

    assign RxD_idle        = (gapCnt == GapFull);
    assign RxD_endofpacket = RxD_idle & ~idleQ;

endmodule

// File: tb/tb_async_receiver.sv
// Directed bench for async_receiver at one oversampling tick per clock
// (8 clocks per bit, 80 clocks per frame).
module tb_async_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       RxD_framing_error;
    logic       RxD_idle;
    logic       RxD_endofpacket;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         readyCount = 0;
    int         feCount = 0;
    int         eopCount = 0;
    int         bothCount = 0;
    int         readyTimes [16];
    logic [7:0] readyData [16];
    int         eopBefore;

    async_receiver #(
        .ClkFrequency(921600),
        .Baud        (115200),
        .Oversampling(8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .RxD              (RxD),
        .RxD_data_ready   (RxD_data_ready),
        .RxD_data         (RxD_data),
        .RxD_framing_error(RxD_framing_error),
        .RxD_idle         (RxD_idle),
        .RxD_endofpacket  (RxD_endofpacket)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampling away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (RxD_data_ready && readyCount < 16) begin
            readyTimes[readyCount] = cyc;
            readyData[readyCount]  = RxD_data;
            readyCount = readyCount + 1;
        end
        if (RxD_framing_error) feCount = feCount + 1;
        if (RxD_endofpacket) eopCount = eopCount + 1;
        if (RxD_data_ready && RxD_framing_error) bothCount = bothCount + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        RxD = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (8) @(negedge clk);
        end
        RxD = stopBit;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] midByte;
        midByte = 8'h3C;

        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, RxD_data}, 32'h0);
        check("rst_ready", {31'd0, RxD_data_ready}, 32'h0);
        check("rst_fe", {31'd0, RxD_framing_error}, 32'h0);
        check("rst_idle", {31'd0, RxD_idle}, 32'h0);
        check("rst_eop", {31'd0, RxD_endofpacket}, 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Back-to-back frames
        sendFrame(8'hA3, 1'b1);
        sendFrame(8'h00, 1'b1);
        RxD = 1'b1;
        repeat (20) @(negedge clk);
        check("b2b_count", readyCount, 2);
        check("b2b_first", {24'd0, readyData[0]}, 32'hA3);
        check("b2b_second", {24'd0, readyData[1]}, 32'h00);
        check("b2b_spacing", readyTimes[1] - readyTimes[0], 80);
        check("b2b_data", {24'd0, RxD_data}, 32'h00);

        // Single frame 0x55
        sendFrame(8'h55, 1'b1);
        RxD = 1'b1;
        repeat (20) @(negedge clk);
        check("x55_count", readyCount, 3);
        check("x55_data", {24'd0, RxD_data}, 32'h55);
        check("x55_fe", feCount, 0);

        // Framing error: stop bit low
        sendFrame(8'hFF, 1'b0);
        RxD = 1'b1;
        repeat (20) @(negedge clk);
        check("fe_count", feCount, 1);
        check("fe_no_ready", readyCount, 3);
        check("fe_data_kept", {24'd0, RxD_data}, 32'h55);

        // Glitches: 2-clk low filtered out, 3-clk low is a false start
        RxD = 1'b0;
        repeat (2) @(negedge clk);
        RxD = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch2_ready", readyCount, 3);
        check("glitch2_fe", feCount, 1);
        RxD = 1'b0;
        repeat (3) @(negedge clk);
        RxD = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch3_ready", readyCount, 3);
        check("glitch3_fe", feCount, 1);

        // Reset during bit 4 of 0x3C, then a clean 0x81
        RxD = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RxD = midByte[i];
            repeat (8) @(negedge clk);
        end
        RxD = midByte[4];
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_data", {24'd0, RxD_data}, 32'h0);
        RxD = 1'b1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_pulse", readyCount, 3);
        sendFrame(8'h81, 1'b1);
        RxD = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_count", readyCount, 4);
        check("midrst_data81", {24'd0, RxD_data}, 32'h81);
        check("midrst_fe", feCount, 1);

        // Idle gap and end-of-packet
        eopBefore = eopCount;
        check("idle_low_early", {31'd0, RxD_idle}, 32'h0);
        repeat (200) @(negedge clk);
        check("idle_high", {31'd0, RxD_idle}, 32'h1);
        check("eop_once", eopCount - eopBefore, 1);
        RxD = 1'b0;
        repeat (8) @(negedge clk);
        check("idle_drop", {31'd0, RxD_idle}, 32'h0);
        RxD = 1'b1;
        repeat (100) @(negedge clk);
        check("after_idle_count", readyCount, 5);
        check("after_idle_data", {24'd0, RxD_data}, 32'hFF);

        check("never_both", bothCount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
